piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_bit_counter.sv | 42 ++++
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg
// Shared definitions for the parallel-in / serial-out serializer.
//   state_t    : controller state encoding (IDLE, SHIFT)
//   cnt_width  : width of the bit counter for a given word width
package piso_pkg;

  // The controller is either waiting for a word or streaming one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The bit counter must hold 0..WIDTH-1. Its width is never allowed to
  // fall below one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter
// Counts which bit of the current word is on the serial output.
// Ports:
//   Clk    : clock, rising edge
//   Rst_n  : asynchronous active-low reset, clears the count
//   clear  : synchronous clear to 0 (new word or end of word)
//   enable : advance by one bit
//   tc     : terminal count, high when the count equals WIDTH-1
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // Clear takes priority over enable. The last bit of a word is always
  // followed by either a reload or a return to idle, and both of those
  // restart the count at 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The terminal-count flag marks the final bit of a word.
  assign tc = (cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
// Accepts a WIDTH-bit word over a valid/ready handshake and sends it out
// one bit per Shift_en strobe. The order is MSB first or LSB first.
// Ports:
//   Clk        : clock, rising edge
//   Rst_n      : asynchronous active-low reset
//   Load_valid : Pdata holds a word to serialize
//   Pdata      : parallel word, sampled only when it is accepted
//   Load_ready : a word offered now is taken at the next edge
//   Shift_en   : bit-rate strobe
//   Dout       : current serial bit
//   Dout_valid : Dout carries a word bit
//   Dout_last  : Dout carries the final bit of a word
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load_valid,
  input  logic [WIDTH-1:0] Pdata,
  output logic             Load_ready,
  input  logic             Shift_en,
  output logic             Dout,
  output logic             Dout_valid,
  output logic             Dout_last
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             tc;
  logic             ready_c;
  logic             accept;
  logic             shift_step;
  logic             cnt_clear;

  // State register. Reset drops any word in flight immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and next-state logic.
  // In SHIFT, ready rises only on the strobe of the last bit. This lets
  // the next word follow with no gap bit.
  always_comb begin
    state_nxt  = state;
    ready_c    = 1'b0;
    shift_step = 1'b0;
    unique case (state)
      IDLE:  ready_c = 1'b1;
      SHIFT: begin
        ready_c    = tc & Shift_en;
        shift_step = Shift_en;
      end
      default: ;
    endcase
    accept = Load_valid & ready_c;
    if (accept) begin
      state_nxt = SHIFT;
    end else if (shift_step && tc) begin
      state_nxt = IDLE;
    end
  end

  // Move the shift register one place toward the output end, filling
  // with 0. For MSB-first the output end is bit WIDTH-1; otherwise it is
  // bit 0.
  always_comb begin
    sr_shifted = '0;
    if (MSB_FIRST != 0) begin
      sr_shifted = {sr[WIDTH-2:0], 1'b0};
    end else begin
      sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end
  end

  // Shift register. After the last bit it is cleared, so Dout reads 0
  // while idle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr <= '0;
    end else if (accept) begin
      sr <= Pdata;
    end else if (shift_step) begin
      sr <= tc ? '0 : sr_shifted;
    end
  end

  // The counter restarts on every accepted word and at the end of a word.
  // Otherwise it advances once per strobe.
  assign cnt_clear = accept | (shift_step & tc);

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clear (cnt_clear),
    .enable(shift_step),
    .tc    (tc)
  );

  assign Load_ready = ready_c;
  assign Dout       = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
  assign Dout_valid = (state == SHIFT);
  assign Dout_last  = (state == SHIFT) && tc;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Drives an MSB-first instance and an LSB-first instance of the
// serializer with the same stimulus. Their outputs are compared against
// a word/bit-index reference model of the serial stream.
module tb_piso_serializer;

  logic       Clk;
  logic       Rst_n;
  logic       Load_valid;
  logic [7:0] Pdata;
  logic       Shift_en;

  logic readyMsb, doutMsb, validMsb, lastMsb;
  logic readyLsb, doutLsb, validLsb, lastLsb;

  int total;
  int bad;

  // Reference model: is a word in flight, which word, and which bit of
  // it (in transmit order) is currently on the line.
  bit       mBusy;
  bit [7:0] mWord;
  int       mIdx;
  bit       lastAccept;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dutMsb (
    .Clk(Clk), .Rst_n(Rst_n), .Load_valid(Load_valid), .Pdata(Pdata),
    .Load_ready(readyMsb), .Shift_en(Shift_en), .Dout(doutMsb),
    .Dout_valid(validMsb), .Dout_last(lastMsb)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dutLsb (
    .Clk(Clk), .Rst_n(Rst_n), .Load_valid(Load_valid), .Pdata(Pdata),
    .Load_ready(readyLsb), .Shift_en(Shift_en), .Dout(doutLsb),
    .Dout_valid(validLsb), .Dout_last(lastLsb)
  );

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check every output of both instances against the model. The
  // expected ready is supplied by the caller.
  task automatic checkAll(input bit expReady);
    bit expMsb, expLsb, expLast;
    expMsb  = mBusy ? mWord[7 - mIdx] : 1'b0;
    expLsb  = mBusy ? mWord[mIdx] : 1'b0;
    expLast = mBusy && (mIdx == 7);
    checkOutput("doutMsb",  32'(doutMsb),  32'(expMsb));
    checkOutput("doutLsb",  32'(doutLsb),  32'(expLsb));
    checkOutput("validMsb", 32'(validMsb), 32'(mBusy));
    checkOutput("validLsb", 32'(validLsb), 32'(mBusy));
    checkOutput("lastMsb",  32'(lastMsb),  32'(expLast));
    checkOutput("lastLsb",  32'(lastLsb),  32'(expLast));
    checkOutput("readyMsb", 32'(readyMsb), 32'(expReady));
    checkOutput("readyLsb", 32'(readyLsb), 32'(expReady));
  endtask

  // One clock cycle: drive inputs on the falling edge, check just after,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input bit valid, input bit [7:0] data, input bit shEn);
    bit expReady;
    bit accept;
    @(negedge Clk);
    Load_valid = valid;
    Pdata      = data;
    Shift_en   = shEn;
    #1;
    expReady = !mBusy || (mIdx == 7 && shEn);
    checkAll(expReady);
    accept     = valid && expReady;
    lastAccept = accept;
    @(posedge Clk);
    if (accept) begin
      mBusy = 1'b1;
      mWord = data;
      mIdx  = 0;
    end else if (mBusy && shEn) begin
      if (mIdx == 7) mBusy = 1'b0;
      else mIdx++;
    end
  endtask

  // Strobe pattern: mode 0 always, mode 1 random, mode 2 every 3rd edge.
  function automatic bit strobe(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return (k % 3) == 2;
  endfunction

  // Hold a word on Pdata with Load_valid high until it is accepted.
  // The wait is bounded, so a design that never accepts still ends.
  task automatic offer(input bit [7:0] data, input int mode);
    int k;
    k = 0;
    lastAccept = 1'b0;
    while (!lastAccept && k < 100) begin
      applyStimulus(1'b1, data, strobe(mode, k));
      k++;
    end
    if (!lastAccept) checkOutput("acceptTimeout", 32'd0, 32'd1);
  endtask

  // Idle cycles with a changing Pdata, which must never reach Dout.
  task automatic drain(input int cycles, input int mode);
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(1'b0, 8'($urandom), strobe(mode, k));
    end
  endtask

  // Assert reset between clock edges and check that the outputs fall at
  // once. Reset is released just after a rising edge, so the next edge
  // is the first chance to accept a word.
  task automatic pulseReset();
    #2;
    Load_valid = 1'b0;
    Rst_n      = 1'b0;
    #1;
    mBusy = 1'b0;
    mIdx  = 0;
    checkOutput("rstDoutMsb",  32'(doutMsb),  32'd0);
    checkOutput("rstDoutLsb",  32'(doutLsb),  32'd0);
    checkOutput("rstValid",    32'(validMsb), 32'd0);
    checkOutput("rstValidLsb", 32'(validLsb), 32'd0);
    checkOutput("rstLast",     32'(lastMsb),  32'd0);
    checkOutput("rstReady",    32'(readyMsb), 32'd1);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
  endtask

  // Directed scenarios first, then randomized traffic, then the summary.
  initial begin
    int gap;
    total = 0;
    bad   = 0;
    mBusy = 1'b0;
    mWord = '0;
    mIdx  = 0;
    lastAccept = 1'b0;
    Rst_n      = 1'b1;
    Load_valid = 1'b0;
    Pdata      = '0;
    Shift_en   = 1'b0;

    @(posedge Clk);
    pulseReset();

    $display("[TB] A5 with a continuous strobe");
    offer(8'hA5, 0);
    drain(10, 0);

    $display("[TB] C3 with a strobe every third edge");
    offer(8'hC3, 2);
    drain(28, 2);

    $display("[TB] F0 then 0F back to back");
    offer(8'hF0, 0);
    offer(8'h0F, 0);
    drain(10, 0);

    $display("[TB] reset in the middle of FF");
    offer(8'hFF, 0);
    drain(3, 0);
    pulseReset();
    offer(8'h3C, 0);
    drain(10, 0);

    $display("[TB] 55 offered in the middle of a word");
    offer(8'h33, 0);
    drain(3, 0);
    offer(8'h55, 0);
    drain(10, 0);

    $display("[TB] randomized traffic");
    for (int w = 0; w < 60; w++) begin
      offer(8'($urandom), 1);
      gap = $urandom_range(0, 3);
      if (gap != 0) drain(gap, 1);
      if (w == 30) begin
        pulseReset();
      end
    end
    drain(40, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
